// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Drives the open-drain clock/data enables to send one odd-parity frame and collects the device ACK.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES       = 6000,
   parameter int unsigned START_TIMEOUT_CYCLES = 750000,
   parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2c,
   input  logic       ps2d,
   input  logic       start,
   input  logic [7:0] tx_data,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       busy,
   output logic       done_tick,
   output logic [1:0] err
);

   localparam logic [19:0] INH_CMP   = 20'(INHIBIT_CYCLES);
   localparam logic [19:0] START_CMP = 20'(START_TIMEOUT_CYCLES);
   localparam logic [19:0] XFER_CMP  = 20'(XFER_TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_STARTBIT,
      S_WAIT_CLK,
      S_SEND,
      S_RELEASE,
      S_FINISH
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  filt_q, filt_d;
   logic        fclk_q, fclk_d;
   logic        fclk_prev_q;
   logic [1:0]  dsync_q;
   logic        d_s;
   logic        fall;
   logic [9:0]  frame_q, frame_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [19:0] cnt_q, cnt_d;
   logic [19:0] cmp;
   logic [19:0] cnt_inc;
   logic        cnt_hit;
   logic        c_oe_q, c_oe_d;
   logic        d_oe_q, d_oe_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [1:0]  err_q, err_d;

   // Clock glitch filter: the filtered level only moves after eight agreeing samples.
   always_comb begin
      filt_d = {ps2c, filt_q[7:1]};
      fclk_d = fclk_q;
      if (filt_q == 8'hFF) begin
         fclk_d = 1'b1;
      end else if (filt_q == 8'h00) begin
         fclk_d = 1'b0;
      end
   end

   assign fall = fclk_prev_q & ~fclk_q;
   assign d_s  = dsync_q[1];

   always_comb begin
      cmp = XFER_CMP;
      case (state_q)
         S_INHIBIT:  cmp = INH_CMP;
         S_WAIT_CLK: cmp = START_CMP;
         default:    cmp = XFER_CMP;
      endcase
   end

   // Saturating count; a hit means this cycle completes the compare interval.
   assign cnt_inc = (cnt_q == cmp) ? cnt_q : cnt_q + 20'd1;
   assign cnt_hit = (cnt_inc == cmp);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      frame_d   = frame_q;
      err_d     = err_q;
      d_oe_d    = d_oe_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_INHIBIT;
               cnt_d   = '0;
               frame_d = {1'b1, ~^tx_data, tx_data};
               err_d   = 2'b00;
            end
         end
         S_INHIBIT: begin
            cnt_d = cnt_inc;
            if (cnt_hit) begin
               state_d = S_STARTBIT;
            end
         end
         S_STARTBIT: begin
            state_d = S_WAIT_CLK;
            cnt_d   = '0;
         end
         S_WAIT_CLK: begin
            cnt_d = cnt_inc;
            if (cnt_hit) begin
               err_d   = 2'b10;
               state_d = S_FINISH;
            end else if (fall) begin
               d_oe_d    = ~frame_q[0];
               bit_cnt_d = 4'd1;
               cnt_d     = '0;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            cnt_d = cnt_inc;
            if (cnt_hit) begin
               err_d   = 2'b11;
               state_d = S_FINISH;
            end else if (fall) begin
               if (bit_cnt_q == 4'd10) begin
                  err_d   = d_s ? 2'b01 : 2'b00;
                  state_d = S_RELEASE;
               end else begin
                  d_oe_d    = ~frame_q[bit_cnt_q];
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         S_RELEASE: begin
            cnt_d = cnt_inc;
            if (cnt_hit) begin
               err_d   = 2'b11;
               state_d = S_FINISH;
            end else if (fclk_q && d_s) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs follow the next state so they are registered alongside it.
      case (state_d)
         S_IDLE, S_INHIBIT, S_RELEASE, S_FINISH: d_oe_d = 1'b0;
         S_STARTBIT:                             d_oe_d = 1'b1;
         default:                                d_oe_d = d_oe_d;
      endcase
      c_oe_d = (state_d == S_INHIBIT) || (state_d == S_STARTBIT);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FINISH);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         filt_q      <= '0;
         fclk_q      <= 1'b0;
         fclk_prev_q <= 1'b0;
         dsync_q     <= 2'b11;
         frame_q     <= '0;
         bit_cnt_q   <= '0;
         cnt_q       <= '0;
         c_oe_q      <= 1'b0;
         d_oe_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 2'b00;
      end else begin
         state_q     <= state_d;
         filt_q      <= filt_d;
         fclk_q      <= fclk_d;
         fclk_prev_q <= fclk_q;
         dsync_q     <= {dsync_q[0], ps2d};
         frame_q     <= frame_d;
         bit_cnt_q   <= bit_cnt_d;
         cnt_q       <= cnt_d;
         c_oe_q      <= c_oe_d;
         d_oe_q      <= d_oe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign ps2c_oe   = c_oe_q;
   assign ps2d_oe   = d_oe_q;
   assign busy      = busy_q;
   assign done_tick = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a behavioural PS/2 device
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH   = 40;
   localparam int STO   = 1500;
   localparam int XTO   = 1200;
   localparam int H     = 24;
   localparam int BOUND = 5000;

   logic       clk      = 1'b0;
   logic       resetn   = 1'b0;
   logic       start    = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       dev_clk  = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2c, ps2d;
   logic       ps2c_oe, ps2d_oe, busy, done_tick;
   logic [1:0] err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   logic [1:0] done_err = 2'b00;
   logic done_coe = 1'b0;
   logic done_doe = 1'b0;
   logic obs[$];

   // Wired-AND open-drain bus with pull-ups
   assign ps2c = dev_clk & ~ps2c_oe;
   assign ps2d = dev_data & ~ps2d_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .START_TIMEOUT_CYCLES(STO),
      .XFER_TIMEOUT_CYCLES(XTO)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .ps2c(ps2c),
      .ps2d(ps2d),
      .start(start),
      .tx_data(tx_data),
      .ps2c_oe(ps2c_oe),
      .ps2d_oe(ps2d_oe),
      .busy(busy),
      .done_tick(done_tick),
      .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done_tick) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
         done_err <= err;
         done_coe <= ps2c_oe;
         done_doe <= ps2d_oe;
      end
   end

   // Line order on the wire: start, data LSB first, odd parity, stop
   function automatic logic [10:0] exp_frame(input logic [7:0] b);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
      f[9]  = (($countones(b) % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   function automatic logic [10:0] obs_vec();
      logic [10:0] v;
      v = 'x;
      for (int i = 0; i < obs.size() && i < 11; i++) v[i] = obs[i];
      return v;
   endfunction

   task automatic launch(input logic [7:0] b);
      @(negedge clk);
      tx_data = b;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      tx_data = 8'($urandom);
   endtask

   // Device: waits for request-to-send, clocks nclk pulses, samples data late in each low phase.
   task automatic device(input int nclk, input bit ack);
      int g;
      g = 0;
      obs.delete();
      while (!(busy && ps2c && !ps2d) && g < BOUND) begin
         @(negedge clk);
         g++;
      end
      n_checks++;
      if (g >= BOUND) begin
         n_fail++;
         $display("FAIL device_rts: no request-to-send, busy=%0b ps2c=%0b ps2d=%0b", busy, ps2c, ps2d);
         return;
      end
      repeat ($urandom_range(20, 40)) @(negedge clk);
      obs.push_back(ps2d);
      for (int k = 1; k <= nclk; k++) begin
         dev_clk = 1'b0;
         repeat (H) @(negedge clk);
         if (k <= 10) obs.push_back(ps2d);
         dev_clk = 1'b1;
         if (k == 10 && ack) dev_data = 1'b0;
         if (k == 11) dev_data = 1'b1;
         repeat (H) @(negedge clk);
      end
      dev_data = 1'b1;
   endtask

   task automatic wait_count(input int c0, input int lim, output bit seen);
      int g;
      g = 0;
      while (done_cnt == c0 && g < lim) begin
         @(negedge clk);
         g++;
      end
      seen = (done_cnt != c0);
   endtask

   task automatic run_frame(input logic [7:0] b, input int nclk, input bit ack, output bit seen);
      int c0;
      c0 = done_cnt;
      fork
         launch(b);
         device(nclk, ack);
      join
      wait_count(c0, BOUND, seen);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (ps2c_oe !== 1'b0) begin n_fail++; $display("FAIL reset_ps2c_oe: got %b want 0", ps2c_oe); end
      n_checks++; if (ps2d_oe !== 1'b0) begin n_fail++; $display("FAIL reset_ps2d_oe: got %b want 0", ps2d_oe); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done_tick !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_tick); end
      n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", err); end
      resetn = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++; if (busy !== 1'b0 || done_cnt != 0) begin n_fail++; $display("FAIL reset_idle: busy=%b done_cnt=%0d want 0/0", busy, done_cnt); end
   endtask

   task automatic test_ack_frames();
      logic [7:0] b;
      bit seen;
      int c0;
      for (int t = 0; t < 4; t++) begin
         b  = (t == 0) ? 8'hED : 8'($urandom);
         c0 = done_cnt;
         run_frame(b, 11, 1'b1, seen);
         n_checks++;
         if (obs_vec() !== exp_frame(b)) begin
            n_fail++; $display("FAIL ack_bits: byte %02h got %b want %b", b, obs_vec(), exp_frame(b));
         end
         n_checks++;
         if (!seen || done_cnt != c0 + 1 || done_err !== 2'b00) begin
            n_fail++; $display("FAIL ack_done: seen=%0b dones=%0d err=%b want 1/1/00", seen, done_cnt - c0, done_err);
         end
         n_checks++;
         if (busy !== 1'b0 || ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0) begin
            n_fail++; $display("FAIL ack_idle: busy=%b c_oe=%b d_oe=%b want 000", busy, ps2c_oe, ps2d_oe);
         end
      end
   endtask

   task automatic test_parity_sweep();
      logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h01};
      logic       pars  [3] = '{1'b1, 1'b1, 1'b0};
      logic [10:0] v;
      bit seen;
      for (int i = 0; i < 3; i++) begin
         run_frame(bytes[i], 11, 1'b1, seen);
         v = obs_vec();
         n_checks++;
         if (v[9] !== pars[i] || v !== exp_frame(bytes[i])) begin
            n_fail++; $display("FAIL parity: byte %02h got frame %b parity %b want parity %b", bytes[i], v, v[9], pars[i]);
         end
         n_checks++;
         if (!seen || done_err !== 2'b00) begin
            n_fail++; $display("FAIL parity_err: byte %02h seen=%0b err=%b want 00", bytes[i], seen, done_err);
         end
      end
   endtask

   task automatic test_inhibit_timing();
      logic [7:0] b;
      int n, c0;
      bit seen;
      b  = 8'($urandom_range(1, 255));
      c0 = done_cnt;
      fork
         begin
            launch(b);
            n = 0;
            while (ps2c_oe && !ps2d_oe && n < INH + 10) begin
               n++;
               @(negedge clk);
            end
            n_checks++; if (n != INH) begin n_fail++; $display("FAIL inhibit_len: got %0d cycles want %0d", n, INH); end
            n_checks++; if (ps2c_oe !== 1'b1 || ps2d_oe !== 1'b1) begin n_fail++; $display("FAIL startbit: c_oe=%b d_oe=%b want 11", ps2c_oe, ps2d_oe); end
            @(negedge clk);
            n_checks++; if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b1) begin n_fail++; $display("FAIL clk_release: c_oe=%b d_oe=%b want 01", ps2c_oe, ps2d_oe); end
            repeat (150) @(negedge clk);
            tx_data = ~b;
            start   = 1'b1;
            @(negedge clk);
            start   = 1'b0;
         end
         device(11, 1'b1);
      join
      wait_count(c0, BOUND, seen);
      repeat (60) @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_frame(b)) begin
         n_fail++; $display("FAIL midframe_start_bits: got %b want %b", obs_vec(), exp_frame(b));
      end
      n_checks++;
      if (done_cnt != c0 + 1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL midframe_start_ignored: dones=%0d busy=%b want 1/0", done_cnt - c0, busy);
      end
   endtask

   task automatic test_nack();
      int c0;
      bit seen;
      c0 = done_cnt;
      run_frame(8'($urandom), 11, 1'b0, seen);
      repeat (20) @(negedge clk);
      n_checks++;
      if (!seen || done_err !== 2'b01) begin n_fail++; $display("FAIL nack_err: seen=%0b err=%b want 01", seen, done_err); end
      n_checks++;
      if (done_cnt != c0 + 1) begin n_fail++; $display("FAIL nack_done_once: got %0d want 1", done_cnt - c0); end
      n_checks++;
      if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0 || err !== 2'b01) begin
         n_fail++; $display("FAIL nack_release: c_oe=%b d_oe=%b err=%b want 0/0/01", ps2c_oe, ps2d_oe, err);
      end
   endtask

   task automatic test_start_timeout();
      int c0, g, r;
      bit seen;
      c0 = done_cnt;
      launch(8'($urandom));
      g = 0;
      while (ps2c_oe && g < BOUND) begin
         @(negedge clk);
         g++;
      end
      r = cyc;
      wait_count(c0, STO + 100, seen);
      repeat (3) @(negedge clk);
      n_checks++;
      if (!seen || done_cyc - r != STO) begin
         n_fail++; $display("FAIL start_timeout_time: seen=%0b delay=%0d want %0d", seen, done_cyc - r, STO);
      end
      n_checks++;
      if (done_err !== 2'b10 || done_doe !== 1'b0) begin
         n_fail++; $display("FAIL start_timeout_err: err=%b d_oe=%b want 10/0", done_err, done_doe);
      end
   endtask

   task automatic test_xfer_timeout();
      int c0, g, s;
      bit seen;
      c0 = done_cnt;
      s  = 0;
      fork
         begin
            launch(8'hED);
            g = 0;
            while (ps2c_oe && g < BOUND) begin @(negedge clk); g++; end
            while (ps2d_oe && g < BOUND) begin @(negedge clk); g++; end
            s = cyc;
         end
         device(4, 1'b1);
      join
      wait_count(c0, XTO + 100, seen);
      repeat (3) @(negedge clk);
      n_checks++;
      if (!seen || done_cyc - s != XTO) begin
         n_fail++; $display("FAIL xfer_timeout_time: seen=%0b delay=%0d want %0d", seen, done_cyc - s, XTO);
      end
      n_checks++;
      if (done_err !== 2'b11 || done_coe !== 1'b0 || done_doe !== 1'b0) begin
         n_fail++; $display("FAIL xfer_timeout_err: err=%b c_oe=%b d_oe=%b want 11/0/0", done_err, done_coe, done_doe);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b1, b2;
      logic busy_at_done, busy_after, busy_accept;
      int c0, g;
      bit seen;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      c0 = done_cnt;
      busy_at_done = 1'b0;
      busy_after   = 1'b1;
      busy_accept  = 1'b0;
      fork
         begin
            launch(b1);
            g = 0;
            while (!done_tick && g < BOUND) begin @(negedge clk); g++; end
            busy_at_done = busy;
            tx_data = ~b2;
            start   = 1'b1;
            @(negedge clk);
            busy_after = busy;
            tx_data = b2;
            @(negedge clk);
            start   = 1'b0;
            busy_accept = busy;
         end
         begin
            device(11, 1'b1);
            device(11, 1'b1);
         end
      join
      wait_count(c0 + 1, BOUND, seen);
      repeat (4) @(negedge clk);
      n_checks++;
      if (busy_at_done !== 1'b1 || busy_after !== 1'b0 || busy_accept !== 1'b1) begin
         n_fail++; $display("FAIL b2b_busy: at_done=%b after=%b accept=%b want 1/0/1", busy_at_done, busy_after, busy_accept);
      end
      n_checks++;
      if (obs_vec() !== exp_frame(b2)) begin
         n_fail++; $display("FAIL b2b_second_bits: got %b want %b", obs_vec(), exp_frame(b2));
      end
      n_checks++;
      if (done_cnt != c0 + 2 || done_err !== 2'b00) begin
         n_fail++; $display("FAIL b2b_done: dones=%0d err=%b want 2/00", done_cnt - c0, done_err);
      end
   endtask

   task automatic test_reset_mid_frame();
      int c0, g;
      c0 = done_cnt;
      fork
         begin
            launch(8'($urandom));
            g = 0;
            while (obs.size() < 6 && g < BOUND) begin @(negedge clk); g++; end
            repeat (H - 6) @(negedge clk);
            @(posedge clk);
            #2;
            resetn = 1'b0;
            #1;
            n_checks++;
            if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0 || busy !== 1'b0 || err !== 2'b00) begin
               n_fail++; $display("FAIL async_reset: c_oe=%b d_oe=%b busy=%b err=%b want 0/0/0/00", ps2c_oe, ps2d_oe, busy, err);
            end
            repeat (4) @(negedge clk);
            resetn = 1'b1;
         end
         device(11, 1'b1);
      join
      repeat (20) @(negedge clk);
      n_checks++;
      if (done_cnt != c0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_no_done: dones=%0d busy=%b want 0/0", done_cnt - c0, busy);
      end
   endtask

   initial begin
      test_reset();
      test_ack_frames();
      test_parity_sweep();
      test_inhibit_timing();
      test_nack();
      test_start_timeout();
      test_xfer_timeout();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
